// File: rtl/riscv_types_pkg.sv
// Shared writeback-path types: pipeline-signal bus, its NOP encoding and the
// mapping from execution units to arbiter request indices.
package riscv_types;

    localparam int EXE_BUS_W = 151;

    typedef logic [EXE_BUS_W-1:0] exe_p_mux_bus_type;

    localparam logic [11:0]       WB_NOP_CODE = 12'h208;
    localparam exe_p_mux_bus_type WB_NOP_BUS  = exe_p_mux_bus_type'(WB_NOP_CODE);

    // Request index order follows the legacy latency-ordered priority: longest first.
    typedef enum logic [3:0] {
        FDIV     = 4'd0,
        FMUL     = 4'd1,
        FADD_SUB = 4'd2,
        DIV      = 4'd3,
        MUL      = 4'd4,
        FSQRT    = 4'd5,
        R4       = 4'd6,
        FP       = 4'd7,
        ALU      = 4'd8
    } wb_unit_idx_e;

endpackage

// File: rtl/wb_age_priority_enc.sv
// One-hot grant: lowest-index aged requester if any request has aged out,
// otherwise the lowest-index valid requester.
module wb_age_priority_enc
    import riscv_types::*;
#(
    parameter int NUM_UNITS = 9
) (
    input  logic [NUM_UNITS-1:0] valid,
    input  logic [NUM_UNITS-1:0] aged,
    output logic [NUM_UNITS-1:0] grant
);

    logic [NUM_UNITS-1:0] cand;

    assign cand  = (|aged) ? aged : valid;
    // Isolate the lowest set bit of the candidate vector.
    assign grant = cand & (~cand + NUM_UNITS'(1));

endmodule

// File: rtl/wb_priority_arbiter.sv
// Writeback arbiter: fixed-priority select with age override, registered
// single-entry output stage with valid/ready backpressure and flush.
module wb_priority_arbiter
    import riscv_types::*;
#(
    parameter int NUM_UNITS = 9,
    parameter int DATA_W    = 32,
    parameter int BUS_W     = 151,
    parameter int AGE_LIMIT = 15,
    parameter int AGE_W     = 8,
    localparam int IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NUM_UNITS-1:0]        req_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] req_result,
    input  logic [NUM_UNITS*BUS_W-1:0]  req_bus,
    output logic [NUM_UNITS-1:0]        req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_result,
    output logic [BUS_W-1:0]            out_bus,
    output logic [IDX_W-1:0]            out_unit
);

    localparam logic [BUS_W-1:0] NOP_BUS = BUS_W'(WB_NOP_BUS[11:0]);

    generate
        if (AGE_LIMIT < 1 || AGE_LIMIT > (2**AGE_W) - 1) begin : g_bad_age_cfg
            $error("wb_priority_arbiter: AGE_LIMIT must be in 1..2**AGE_W-1");
        end
        if (BUS_W < 12) begin : g_bad_bus_cfg
            $error("wb_priority_arbiter: BUS_W must hold the 12-bit NOP code");
        end
    endgenerate

    logic [NUM_UNITS-1:0][AGE_W-1:0] age_reg;
    logic [NUM_UNITS-1:0][AGE_W-1:0] age_next;
    logic [NUM_UNITS-1:0]            aged;
    logic [NUM_UNITS-1:0]            grant_raw;
    logic                            load;
    logic                            grant_en;
    logic                            take;
    logic [DATA_W-1:0]               sel_result;
    logic [BUS_W-1:0]                sel_bus;
    logic [IDX_W-1:0]                sel_idx;

    assign load      = !out_valid || out_ready;
    assign grant_en  = reset_n && load && !flush;
    assign req_ready = grant_en ? grant_raw : '0;
    assign take      = |req_ready;

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_age
            assign aged[gi] = req_valid[gi] && (age_reg[gi] >= AGE_W'(AGE_LIMIT));
            // Age only advances on cycles where the output stage could have accepted.
            assign age_next[gi] =
                (flush || !req_valid[gi] || req_ready[gi]) ? '0 :
                (load && age_reg[gi] != {AGE_W{1'b1}})     ? age_reg[gi] + AGE_W'(1) :
                                                             age_reg[gi];
        end
    endgenerate

    wb_age_priority_enc #(
        .NUM_UNITS (NUM_UNITS)
    ) u_enc (
        .valid (req_valid),
        .aged  (aged),
        .grant (grant_raw)
    );

    always_comb begin
        sel_result = '0;
        sel_bus    = '0;
        sel_idx    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant_raw[i]) begin
                sel_result = req_result[i*DATA_W +: DATA_W];
                sel_bus    = req_bus[i*BUS_W +: BUS_W];
                sel_idx    = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age_reg    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_bus    <= NOP_BUS;
            out_unit   <= '0;
        end else begin
            age_reg <= age_next;
            if (flush || (load && !take)) begin
                out_valid  <= 1'b0;
                out_result <= '0;
                out_bus    <= NOP_BUS;
                out_unit   <= '0;
            end else if (take) begin
                out_valid  <= 1'b1;
                out_result <= sel_result;
                out_bus    <= sel_bus;
                out_unit   <= sel_idx;
            end
        end
    end

endmodule
